// File: rtl/pdm_voice_scheduler_pkg.sv
// Shared constants and helpers for the PDM voice scheduler: FSM encodings,
// midscale code, default rates and the mixer accumulator width.
package pdm_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [7:0] MIDSCALE = 8'h80;

  localparam int unsigned DEF_CLK_DIV    = 1000;
  localparam int unsigned DEF_NUM_VOICES = 4;

  // Sum of NUM_VOICES signed samples needs log2(NUM_VOICES) guard bits.
  function automatic int acc_width(input int sample_width, input int num_voices);
    return sample_width + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/pdm_voice_scheduler_if.sv
// Bundle between the scheduler and the system side (config port + shared ROM + DAC feed).
// The master modport is the system side; the scheduler uses the slave modport.
interface pdm_voice_scheduler_if
  import pdm_sched_pkg::*;
#(
  parameter int NUM_VOICES   = DEF_NUM_VOICES,
  parameter int PHASE_WIDTH  = 12,
  parameter int SAMPLE_WIDTH = 8
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                    cfg_we;
  logic [VW-1:0]           cfg_voice;
  logic [PHASE_WIDTH-1:0]  cfg_step;
  logic                    cfg_enable;
  logic [PHASE_WIDTH-1:0]  rom_addr;
  logic [SAMPLE_WIDTH-1:0] rom_data;
  logic                    tick;
  logic                    busy;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    sample_valid;

  modport master (
    output cfg_we, cfg_voice, cfg_step, cfg_enable, rom_data,
    input  rom_addr, tick, busy, sample, sample_valid
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_step, cfg_enable, rom_data,
    output rom_addr, tick, busy, sample, sample_valid
  );

endinterface

// File: rtl/pdm_voice_scheduler_rate_tick_gen.sv
// Free-running divider producing a one-cycle strobe every DIV clocks,
// asserted while the count sits at its terminal value.
module rate_tick_gen
  import pdm_sched_pkg::*;
#(
  parameter int unsigned DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == TERMINAL);

endmodule

// File: rtl/pdm_voice_scheduler.sv
// Time-multiplexes one shared wave ROM across NUM_VOICES phase accumulators each
// sample period and mixes the voices into one offset-binary sample for the PDM DAC.
module pdm_voice_scheduler
  import pdm_sched_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int NUM_VOICES   = DEF_NUM_VOICES,
  parameter int PHASE_WIDTH  = 12,
  parameter int SAMPLE_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  pdm_voice_scheduler_if.slave bus
);
  localparam int LOGN = $clog2(NUM_VOICES);
  localparam int VW   = (NUM_VOICES > 1) ? LOGN : 1;
  localparam int AW   = acc_width(SAMPLE_WIDTH, NUM_VOICES);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MID = {MIDSCALE[7], {(SAMPLE_WIDTH-1){1'b0}}};

  logic                   tick;
  logic [1:0]             state;
  logic [VW-1:0]          k;
  logic [PHASE_WIDTH-1:0] phase         [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] step          [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] shadow_step   [NUM_VOICES];
  logic [NUM_VOICES-1:0]  enable;
  logic [NUM_VOICES-1:0]  shadow_enable;
  logic [PHASE_WIDTH-1:0] addr_hold;
  logic                   data_valid;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   rom_ext;
  logic signed [AW-1:0]   acc_next;
  logic [SAMPLE_WIDTH-1:0] acc_shift;
  logic [SAMPLE_WIDTH-1:0] sample_r;
  logic                   sample_valid_r;

  rate_tick_gen #(.DIV(CLK_DIV)) u_rate_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) shadow_step[v] <= '0;
      shadow_enable <= '0;
    end else if (bus.cfg_we) begin
      shadow_step[bus.cfg_voice]   <= bus.cfg_step;
      shadow_enable[bus.cfg_voice] <= bus.cfg_enable;
    end
  end

  // Shadows commit only on tick, so a write in the tick cycle waits a full frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        step[v]  <= '0;
        phase[v] <= '0;
      end
      enable <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (tick) begin
          step[v]   <= shadow_step[v];
          enable[v] <= shadow_enable[v];
          if (!shadow_enable[v]) phase[v] <= '0;
        end else if (state == ST_RUN && k == VW'(v)) begin
          phase[v] <= enable[v] ? phase[v] + step[v] : '0;
        end
      end
    end
  end

  // ROM data lags its address by one cycle, hence the data_valid pipeline bit.
  assign rom_ext   = AW'($signed(bus.rom_data));
  assign acc_next  = acc + (data_valid ? rom_ext : AW'(0));
  assign acc_shift = SAMPLE_WIDTH'(acc_next >>> LOGN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      k              <= '0;
      addr_hold      <= '0;
      data_valid     <= 1'b0;
      acc            <= '0;
      sample_r       <= MID;
      sample_valid_r <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      data_valid     <= (state == ST_RUN) && enable[k];
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_RUN;
            k     <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          acc       <= acc_next;
          addr_hold <= phase[k];
          if (k == LAST) state <= ST_DRAIN;
          else           k     <= k + VW'(1);
        end
        ST_DRAIN: begin
          acc            <= acc_next;
          sample_r       <= acc_shift ^ MID;
          sample_valid_r <= 1'b1;
          state          <= ST_OUT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr     = (state == ST_RUN) ? phase[k] : addr_hold;
  assign bus.tick         = tick;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;

endmodule

// File: tb/tb_pdm_voice_scheduler.sv
// Directed bench for pdm_voice_scheduler: tick timing, single-voice sweep, mixing,
// phase wrap, config commit timing and mid-frame reset.
module tb_pdm_voice_scheduler;
  import pdm_sched_pkg::*;

  localparam int NV  = 4;
  localparam int PW  = 12;
  localparam int SW  = 8;
  localparam int DIV = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdm_voice_scheduler_if #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW)) bus ();

  pdm_voice_scheduler #(
    .CLK_DIV(DIV), .NUM_VOICES(NV), .PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ROM model with one-cycle latency: identity on addr[7:0] or a constant.
  logic       rom_ident = 1'b1;
  logic [7:0] rom_const = 8'h00;
  always @(posedge clk) bus.rom_data <= rom_ident ? bus.rom_addr[7:0] : rom_const;

  int assertCount = 0;
  int failCount   = 0;

  logic [PW-1:0] fAddr [NV];
  logic [SW-1:0] fSample;
  int fValidAt, fBusy, fTicks;
  int n, valids;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int voice, input int stp, input logic en);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_voice  = 2'(voice);
    bus.cfg_step   = PW'(stp);
    bus.cfg_enable = en;
    @(negedge clk);
    bus.cfg_we     = 1'b0;
  endtask

  // Returns at the negedge inside the tick cycle; cycles counted in cnt.
  task automatic waitTick(input string tag, output int cnt);
    int seen;
    int vcount;
    cnt = 0; seen = 0; vcount = 0;
    while (seen == 0 && cnt < 2 * DIV) begin
      @(negedge clk);
      cnt++;
      if (bus.sample_valid) vcount++;
      if (bus.tick) seen = 1;
    end
    checkOutput({tag, "_tick_seen"}, seen, 1);
    checkOutput({tag, "_no_stray_valid"}, vcount, 0);
  endtask

  task automatic captureFrame();
    fValidAt = 0; fBusy = 0; fTicks = 0; fSample = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.cfg_we = 1'b0;
      if (c <= NV) fAddr[c-1] = bus.rom_addr;
      if (bus.busy) fBusy++;
      if (bus.tick) fTicks++;
      if (bus.sample_valid) begin
        fValidAt = c;
        fSample  = bus.sample;
      end
    end
  endtask

  task automatic checkFrame(input string tag, input logic [SW-1:0] expSample);
    checkOutput({tag, "_valid_latency"}, fValidAt, NV + 2);
    checkOutput({tag, "_busy_cycles"}, fBusy, NV + 2);
    checkOutput({tag, "_sample"}, fSample, expSample);
  endtask

  logic [PW-1:0] wrapAddr [4];
  logic [SW-1:0] wrapSmp  [4];
  logic [PW-1:0] cfgAddr  [4];
  logic [SW-1:0] cfgSmp   [4];

  initial begin
    wrapAddr = '{12'h000, 12'hFFF, 12'hFFE, 12'hFFD};
    wrapSmp  = '{8'h80, 8'h7F, 8'h7F, 8'h7F};
    cfgAddr  = '{12'd0, 12'd0, 12'd5, 12'd10};
    cfgSmp   = '{8'h80, 8'h80, 8'h81, 8'h82};

    bus.cfg_we = 1'b0; bus.cfg_voice = '0; bus.cfg_step = '0; bus.cfg_enable = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_sample", bus.sample, 8'h80);
    checkOutput("rst_valid", bus.sample_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_tick", bus.tick, 0);
    checkOutput("rst_addr", bus.rom_addr, 0);
    rst = 1'b1;

    waitTick("t1", n);
    checkOutput("first_tick_cycle", n, DIV - 1);
    checkOutput("tick_cycle_busy", bus.busy, 0);
    captureFrame();
    checkFrame("idle_frame", 8'h80);
    checkOutput("tick_width", fTicks, 0);
    waitTick("t2", n);
    checkOutput("tick_period", n + 8, DIV);
    captureFrame();

    applyStimulus(0, 16, 1'b1);
    for (int f = 0; f < 3; f++) begin
      waitTick($sformatf("sv%0d", f), n);
      captureFrame();
      checkOutput($sformatf("sv%0d_addr", f), fAddr[0], 16 * f);
      checkFrame($sformatf("sv%0d", f), SW'(8'h80 + 4 * f));
    end

    rom_ident = 1'b0;
    rom_const = 8'h7F;
    for (int v = 0; v < NV; v++) applyStimulus(v, 0, 1'b1);
    waitTick("mix7f", n);
    captureFrame();
    checkFrame("mix_7f", 8'hFF);

    rom_const = 8'h80;
    waitTick("mix80", n);
    captureFrame();
    checkFrame("mix_80", 8'h00);

    rom_const = 8'h7F;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    applyStimulus(3, 0, 1'b0);
    waitTick("v2", n);
    captureFrame();
    checkFrame("v2_only", 8'h9F);

    rom_ident = 1'b1;
    applyStimulus(2, 0, 1'b0);
    applyStimulus(0, 12'hFFF, 1'b1);
    for (int f = 0; f < 4; f++) begin
      waitTick($sformatf("wrap%0d", f), n);
      captureFrame();
      checkOutput($sformatf("wrap%0d_addr", f), fAddr[0], wrapAddr[f]);
      checkFrame($sformatf("wrap%0d", f), wrapSmp[f]);
    end

    applyStimulus(0, 0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      waitTick($sformatf("cfg%0d", f), n);
      if (f == 0) begin
        bus.cfg_we = 1'b1; bus.cfg_voice = 2'd1; bus.cfg_step = 12'd5; bus.cfg_enable = 1'b1;
      end
      captureFrame();
      checkOutput($sformatf("cfg%0d_v1_addr", f), fAddr[1], cfgAddr[f]);
      checkFrame($sformatf("cfg%0d", f), cfgSmp[f]);
    end

    waitTick("pre_rst", n);
    @(negedge clk);
    @(negedge clk);
    checkOutput("prerst_v1_addr", bus.rom_addr, 15);
    @(negedge clk);
    checkOutput("prerst_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_valid", bus.sample_valid, 0);
    checkOutput("midrst_sample", bus.sample, 8'h80);
    checkOutput("midrst_addr", bus.rom_addr, 0);
    checkOutput("midrst_tick", bus.tick, 0);
    valids = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.sample_valid) valids++;
    end
    checkOutput("midrst_no_partial", valids, 0);
    rst = 1'b1;

    waitTick("post_rst", n);
    checkOutput("post_rst_tick_cycle", n, DIV - 1);
    captureFrame();
    checkFrame("post_rst", 8'h80);
    checkOutput("post_rst_v1_addr", fAddr[1], 0);
    waitTick("post_rst2", n);
    captureFrame();
    checkOutput("post_rst2_v1_addr", fAddr[1], 0);
    checkFrame("post_rst2", 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pdm_voice_scheduler.md
Name: pdm_voice_scheduler

Overview:
Time-multiplexes one shared 4096x8 sine/wave ROM across NUM_VOICES phase-accumulator voices, once per audio sample period. Mixes the voice outputs into one offset-binary sample for the downstream pdm DAC. Owns the 48 kHz sample-rate tick derived from the 48 MHz system clock, so the DAC path needs no external strobe. Sits between the register/config interface and the ROM + pdm datapath.

Parameters:
CLK_DIV, 1000, system clocks per output sample (48 MHz / 48 kHz); must be >= NUM_VOICES+4
NUM_VOICES, 4, voice count; power of two, 1..16
PHASE_WIDTH, 12, phase accumulator / ROM address width
SAMPLE_WIDTH, 8, ROM data and output sample width

Ports:
clk  in  1  system clock, 48 MHz
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe, one cycle
cfg_voice  in  log2(NUM_VOICES)  voice index for the write (min width 1)
cfg_step  in  PHASE_WIDTH  phase increment per sample
cfg_enable  in  1  voice enable
rom_addr  out  PHASE_WIDTH  ROM read address; ROM has fixed 1-cycle read latency
rom_data  in  SAMPLE_WIDTH  ROM data, signed two's complement
tick  out  1  one-cycle sample-rate pulse
busy  out  1  high while a frame is being scheduled
sample  out  SAMPLE_WIDTH  mixed sample, offset binary, to pdm.sample
sample_valid  out  1  one-cycle pulse when sample updates

Behaviour:
- Reset (rst=0, async): divider=0, tick=0, busy=0, rom_addr=0, sample=8'h80 (midscale), sample_valid=0, all phases/steps/enables and shadows=0, FSM=IDLE.
- Divider: counts 0..CLK_DIV-1; tick=1 for the one cycle in which count==CLK_DIV-1. First tick occurs CLK_DIV cycles after reset release. Period is exactly CLK_DIV.
- Config: cfg_we writes step/enable into a per-voice shadow. Shadows copy to active registers in the tick cycle. A write in the tick cycle itself lands in the shadow only and takes effect at the following tick. Writes during busy are legal.
- FSM: IDLE -> RUN on tick. RUN lasts NUM_VOICES cycles; in RUN cycle k, rom_addr=phase[k]. Then RUN -> DRAIN (1 cycle) -> OUT (1 cycle) -> IDLE. busy=1 in RUN/DRAIN/OUT.
- Accumulate: rom_data returned for voice k is sign-extended to SAMPLE_WIDTH+log2(NUM_VOICES) bits. It is added to an accumulator that is cleared at tick. A disabled voice adds 0.
- Phase update: when voice k is addressed, phase[k] <= (phase[k]+step[k]) mod 2^PHASE_WIDTH. The sample uses the pre-increment phase. A disabled voice holds phase=0; enabling starts it from 0.
- Output (OUT state): sample <= (acc >>> log2(NUM_VOICES)) with MSB inverted (signed -> offset binary). sample_valid=1 for that cycle. Result range is always within SAMPLE_WIDTH, so no clipping is needed. sample holds between updates.
- Latency: sample_valid is high exactly NUM_VOICES+2 cycles after the tick cycle.
- rom_addr holds its last value outside RUN.
- Reset mid-frame: everything clears immediately. No partial sample is emitted. The next sample_valid follows the first post-reset tick.
- step=0 on an enabled voice: constant ROM[0] contribution, which is legal.

Decomposition:
- Package pdm_sched_pkg: FSM state enum (IDLE, RUN, DRAIN, OUT), MIDSCALE constant 8'h80, default CLK_DIV/NUM_VOICES, accumulator-width function.
- Sub-module rate_tick_gen: parameterised CLK_DIV divider producing tick. It is reused for other rate strobes.

Test Plan:
- Reset/tick: hold rst=0 for 5 cycles, release -> sample=0x80, sample_valid=0; tick at cycle 999 after release, then every 1000 cycles; busy high for 6 cycles per tick.
- Single voice, ROM model rom_data=addr[7:0], voice0 enable step=16 -> rom_addr 0,16,32 on successive frames; sample 0x80,0x84,0x88; sample_valid NUM_VOICES+2=6 cycles after each tick.
- Full-scale mix, constant ROM 0x7F, all 4 voices enabled -> sample=0xFF. Constant ROM 0x80 -> sample=0x00. Only voice2 enabled with 0x7F -> sample=0x9F.
- Wrap: voice0 step=0xFFF -> rom_addr in RUN cycle 0 sequence 0x000,0xFFF,0xFFE,0xFFD.
- Config timing: cfg_we (voice1, step=5, enable=1) in a tick cycle -> voice1 contributes 0 that frame; it is addressed from the next frame, phases 0,5,10.
- Reset mid-RUN: assert rst during RUN cycle 2 -> all outputs reset asynchronously, no sample_valid in that frame; the next sample_valid comes 1000+6 cycles after release, with voices disabled and sample=0x80.
